// File: rtl/result_packer_pkg.sv
// Shared defaults and derived widths for the result bit packer and its word FIFO.
package result_packer_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;
  localparam int IDX_W     = $clog2(WIDTH_DEF);
  localparam int PTR_W     = $clog2(DEPTH_DEF);
  localparam int CNT_W     = $clog2(DEPTH_DEF + 1);
endpackage

// File: rtl/result_packer_fifo.sv
// DEPTH x WIDTH synchronous word FIFO with flush, occupancy count and a registered head word.
import result_packer_pkg::*;

module result_packer_fifo #(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             pop_en
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] head_q;
  logic             push_en;

  always_comb begin
    full    = (cnt == FULL_CNT);
    pop_en  = pop && (cnt != '0);
    push_en = push && (!full || pop_en);
    rd_nxt  = pop_en ? rd_ptr + 1'b1 : rd_ptr;
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      head_q <= mem[0];
    end else begin
      if (push_en) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_nxt;
      case ({push_en, pop_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      // A word written into the slot that becomes the head bypasses the array.
      head_q <= (push_en && (wr_ptr == rd_nxt)) ? push_data : mem[rd_nxt];
    end
  end

  assign out_valid = (cnt != '0);
  assign head      = head_q;
  assign count     = cnt;

endmodule

// File: rtl/result_packer.sv
// Packs qualified result bits LSB-first into words and buffers them; flags words lost to backpressure.
import result_packer_pkg::*;

module result_packer #(
  parameter int  WIDTH = WIDTH_DEF,
  parameter int  DEPTH = DEPTH_DEF,
  localparam int IDX_W = $clog2(WIDTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             C0,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] word_nxt;
  logic             last_bit, complete, drop;
  logic             fifo_full, fifo_pop_en;
  logic             ovf_q;

  always_comb begin
    word_nxt      = shift_q;
    word_nxt[idx] = in_bit;
    last_bit      = (idx == LAST_IDX);
    complete      = in_valid && last_bit;
    drop          = complete && fifo_full && !fifo_pop_en;
  end

  always_ff @(posedge C0 or negedge reset) begin
    if (!reset) begin
      idx     <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else if (flush) begin
      idx     <= '0;
      shift_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (in_valid) begin
        if (last_bit) begin
          idx     <= '0;
          shift_q <= '0;
        end else begin
          idx     <= idx + 1'b1;
          shift_q <= word_nxt;
        end
      end
      if (drop) ovf_q <= 1'b1;
    end
  end

  result_packer_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_sys   (C0),
    .rst_b     (reset),
    .push      (complete),
    .push_data (word_nxt),
    .pop       (out_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .head      (out_bits),
    .count     (count),
    .full      (fifo_full),
    .pop_en    (fifo_pop_en)
  );

  assign overflow = ovf_q;

endmodule

// File: tb/tb_result_packer.sv
// Directed bench for result_packer: packing, gaps, overflow, pop-while-full, flush, async reset.
module tb_result_packer;
  logic       C0 = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_bits;
  logic [2:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  result_packer #(.WIDTH(8), .DEPTH(4)) dut (
    .C0        (C0),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 C0 = ~C0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge C0);
    #1;
  endtask

  // Feeds one word LSB first; count must stay at cnt_pre until the last bit lands.
  task automatic feed_word(input logic [7:0] w, input bit gaps, input bit pop_last,
                           input logic [2:0] cnt_pre);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        chk("count_before_last_bit", {29'd0, count}, {29'd0, cnt_pre});
        if (pop_last) out_ready = 1'b1;
      end
      in_valid = 1'b1;
      in_bit   = w[i];
      tick();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (gaps && i != 7) begin
        in_bit = ~in_bit;
        tick();
        tick();
      end
    end
  endtask

  task automatic drain(input logic [7:0] w0, input logic [7:0] w1,
                       input logic [7:0] w2, input logic [7:0] w3);
    logic [7:0] exp_q [4];
    exp_q = '{w0, w1, w2, w3};
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", {31'd0, out_valid}, 32'd1);
      chk("drain_word", {24'd0, out_bits}, {24'd0, exp_q[k]});
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_count", {29'd0, count}, 32'd0);
  endtask

  initial begin
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_bits", {24'd0, out_bits}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    @(negedge C0);
    reset = 1'b1;
    tick();

    // 1,0,1,1,0,0,1,0 bit0 first = 8'h4D
    out_ready = 1'b1;  // ready with nothing valid has no effect
    tick();
    chk("ready_while_empty", {29'd0, count}, 32'd0);
    out_ready = 1'b0;
    feed_word(8'h4D, 1'b0, 1'b0, 3'd0);
    chk("w4d_valid", {31'd0, out_valid}, 32'd1);
    chk("w4d_bits", {24'd0, out_bits}, 32'h4D);
    chk("w4d_count", {29'd0, count}, 32'd1);
    tick();
    chk("w4d_stable", {24'd0, out_bits}, 32'h4D);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("w4d_popped", {31'd0, out_valid}, 32'd0);

    feed_word(8'hA5, 1'b1, 1'b0, 3'd0);
    chk("wa5_bits", {24'd0, out_bits}, 32'hA5);
    chk("wa5_count", {29'd0, count}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill, then overflow on the 5th word
    feed_word(8'h01, 1'b0, 1'b0, 3'd0);
    feed_word(8'h02, 1'b0, 1'b0, 3'd1);
    feed_word(8'h03, 1'b0, 1'b0, 3'd2);
    feed_word(8'h04, 1'b0, 1'b0, 3'd3);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_no_ovf", {31'd0, overflow}, 32'd0);
    feed_word(8'h05, 1'b0, 1'b0, 3'd4);
    chk("drop_ovf", {31'd0, overflow}, 32'd1);
    chk("drop_count", {29'd0, count}, 32'd4);
    drain(8'h01, 8'h02, 8'h03, 8'h04);
    chk("ovf_sticky", {31'd0, overflow}, 32'd1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_ovf", {31'd0, overflow}, 32'd0);

    // 5th word completes together with a pop
    feed_word(8'h01, 1'b0, 1'b0, 3'd0);
    feed_word(8'h02, 1'b0, 1'b0, 3'd1);
    feed_word(8'h03, 1'b0, 1'b0, 3'd2);
    feed_word(8'h04, 1'b0, 1'b0, 3'd3);
    feed_word(8'h05, 1'b0, 1'b1, 3'd4);
    chk("popfull_ovf", {31'd0, overflow}, 32'd0);
    chk("popfull_count", {29'd0, count}, 32'd4);
    drain(8'h02, 8'h03, 8'h04, 8'h05);

    // Partial word, then flush with a same-cycle bit and pop request
    in_valid = 1'b1;
    in_bit   = 1'b0;
    tick();
    tick();
    tick();
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("flush_count", {29'd0, count}, 32'd0);
    feed_word(8'hFF, 1'b0, 1'b0, 3'd0);
    chk("wff_bits", {24'd0, out_bits}, 32'hFF);
    chk("wff_count", {29'd0, count}, 32'd1);
    chk("wff_ovf", {31'd0, overflow}, 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Async reset mid-word with two words buffered
    feed_word(8'h11, 1'b0, 1'b0, 3'd0);
    feed_word(8'h22, 1'b0, 1'b0, 3'd1);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    tick();
    tick();
    tick();
    in_valid = 1'b0;
    chk("pre_rst_count", {29'd0, count}, 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_bits", {24'd0, out_bits}, 32'd0);
    chk("arst_count", {29'd0, count}, 32'd0);
    chk("arst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    feed_word(8'h3C, 1'b0, 1'b0, 3'd0);
    chk("w3c_bits", {24'd0, out_bits}, 32'h3C);
    chk("w3c_count", {29'd0, count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/result_packer.md
# result_packer

Downstream collector for the 1-bit `io_result` stream of the multi-clock sub-component pair. It samples qualified result bits, packs them LSB-first into WIDTH-bit words, and buffers completed words in a DEPTH-entry FIFO. The FIFO presents them on a valid/ready port to the next consumer, normally a register-read or trace unit. A sticky overflow flag reports words lost to backpressure.

## Interface
Parameters:
- WIDTH, 8: bits per packed word; must be ≥ 2.
- DEPTH, 4: FIFO entries; power of two, ≥ 2.

Ports:
- C0  in  1  clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- in_valid  in  1  qualifies in_bit this cycle.
- in_bit  in  1  result bit (driven from io_result).
- flush  in  1  synchronous clear of partial word, FIFO and overflow.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer accepts head this cycle.
- out_bits  out  WIDTH  FIFO head word.
- count  out  clog2(DEPTH+1)  FIFO occupancy.
- overflow  out  1  sticky: a completed word was dropped.

## Operation
- Bit counter `idx` runs 0..WIDTH-1. On each in_valid cycle, in_bit is written to shift-word bit `idx` and `idx` increments.
- The word completes when in_valid is high and `idx == WIDTH-1`:
  - The full word, including the current bit, is pushed into the FIFO on that edge.
  - `idx` wraps to 0.
  - The partial-word register is cleared.
- Pop occurs when out_valid && out_ready; the head advances on that edge.
- FIFO full with a word completing:
  - If a pop occurs in the same cycle, the push succeeds and count is unchanged.
  - Otherwise the word is dropped, overflow is set, `idx` still wraps, and FIFO contents are unchanged.
- Push and pop together when not full: count is unchanged and both pointers advance.
- Empty: out_valid=0; out_bits is don't-care but holds the stale slot value; out_ready is ignored.
- flush takes priority over everything in its cycle:
  - `idx`, partial word, pointers, count and overflow go to 0.
  - A same-cycle in_valid bit and a same-cycle pop are discarded.
- overflow clears only on reset or flush.
- Pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from count, not from pointer compare.

## Timing
- Reset values: out_valid=0, out_bits=0 (storage cleared), count=0, overflow=0, idx=0.
- Latency: last bit of a word sampled at edge t gives out_valid=1 and the word on out_bits during cycle t+1. Minimum throughput is one word per WIDTH in_valid cycles.
- out_valid, out_bits and count are driven from registers, with no combinational path from in_* or out_ready.
- out_ready may be high while out_valid is low; this has no effect.
- out_bits is stable while out_valid=1 and no pop has occurred.
- Reset asserted mid-word or with a full FIFO takes effect asynchronously: all outputs drop to reset values without waiting for C0. Release is sampled at the next C0 edge; the first in_valid after release goes to bit 0.

## Structure
- Shared package `result_packer_pkg`:
  - Defaults WIDTH_DEF=8, DEPTH_DEF=4.
  - Derived constants IDX_W=clog2(WIDTH), PTR_W=clog2(DEPTH), CNT_W=clog2(DEPTH+1).
- Sub-module `result_packer_fifo`: synchronous DEPTH×WIDTH FIFO with push/pop/flush, count, and registered head output. It is reused elsewhere for word buffering.
- The top level holds the bit counter, shift word, and overflow/drop logic.

## Test plan
- Reset, then feed 8 valid bits 1,0,1,1,0,0,1,0 (bit0 first) -> out_valid rises the cycle after the 8th bit with out_bits=8'h4D and count=1.
- Interleave in_valid=0 gaps between bits of word 8'hA5 -> same 8'hA5 result; gaps do not advance idx.
- Hold out_ready=0 and push 4 words 01,02,03,04 -> count=4. A 5th word 05 is dropped and overflow=1. Drain with out_ready=1 -> 01,02,03,04 in order, then out_valid=0; overflow stays 1.
- FIFO full, 5th word completes in the same cycle as a pop -> no drop, overflow=0, count stays 4. Drained sequence is 02,03,04,05.
- Feed 3 bits, assert flush together with an in_valid bit, then feed 8'hFF -> out_bits=8'hFF (no residue), count=1, overflow=0.
- Assert reset asynchronously mid-word with count=2 -> outputs zero immediately. After release, 8 bits of 8'h3C yield out_bits=8'h3C and count=1.
